player_pos_tracker: RTL and testbench

//   Parametrised position tracker for all players on the circular board: one register bank
//   per player replaces the per-player counters. Holds tile position and lap count for up to
//   MAX_PLAYERS, applies forward/backward moves with modular wrap, and reports landing

---
 rtl/player_pos_tracker_pkg.sv | 24 ++
 rtl/player_pos_tracker_ring_step.sv | 47 ++++
 rtl/player_pos_tracker.sv | 126 ++++++++++++
 tb/tb_player_pos_tracker.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pos_tracker_pkg.sv
// Shared board constants, default sizing and the start-offset rule for the
// player position tracker.
package player_pos_tracker_pkg;

  localparam int DEF_MAX_PLAYERS = 4;
  localparam int DEF_BOARD_SIZE  = 24;
  localparam int DEF_STEP_W      = 3;
  localparam int DEF_LAP_W       = 4;
  localparam int N_W             = 4;

  typedef logic [$clog2(DEF_BOARD_SIZE)-1:0] pos_t;
  typedef logic [DEF_LAP_W-1:0]              lap_t;

  // Evenly spaced start tile for slot i of n; only called with constant
  // arguments so it folds to a small ROM.
  function automatic int start_offset(input int i, input int n, input int board);
    int r;
    r = 0;
    if (n > 0 && i < n) r = (i * board) / n;
    else                r = 0;
    return r;
  endfunction

endpackage

// File: rtl/player_pos_tracker_ring_step.sv
// Combinational one-step move around the ring: a single add or subtract with
// one correction, flagging a forward wrap or a backward borrow.
module player_pos_tracker_ring_step #(
  parameter int BOARD_SIZE = 24,
  parameter int STEP_W     = 3,
  parameter int PW         = 5
) (
  input  logic [PW-1:0]     pos,
  input  logic [STEP_W-1:0] step,
  input  logic              back,
  output logic [PW-1:0]     next_pos,
  output logic              wrap,
  output logic              borrow
);

  localparam logic [PW:0] BS_EXT = (PW+1)'(BOARD_SIZE);

  logic [PW:0] ext_pos;
  logic [PW:0] ext_step;
  logic [PW:0] sum;

  // One extra bit of headroom keeps pos+BOARD_SIZE and pos+step exact.
  always_comb begin
    ext_pos  = {1'b0, pos};
    ext_step = (PW+1)'(step);
    sum      = ext_pos + ext_step;
    next_pos = '0;
    wrap     = 1'b0;
    borrow   = 1'b0;
    if (back) begin
      if (ext_step > ext_pos) begin
        next_pos = PW'(ext_pos + BS_EXT - ext_step);
        borrow   = 1'b1;
      end else begin
        next_pos = PW'(ext_pos - ext_step);
      end
    end else begin
      if (sum >= BS_EXT) begin
        next_pos = PW'(sum - BS_EXT);
        wrap     = 1'b1;
      end else begin
        next_pos = PW'(sum);
      end
    end
  end

endmodule

// File: rtl/player_pos_tracker.sv
// Per-player tile/lap register banks for the circular board, move execution
// with wrap and lap counting, and landing-collision (catch) reporting.
module player_pos_tracker
  import player_pos_tracker_pkg::*;
#(
  parameter  int MAX_PLAYERS = DEF_MAX_PLAYERS,
  parameter  int BOARD_SIZE  = DEF_BOARD_SIZE,
  parameter  int STEP_W      = DEF_STEP_W,
  parameter  int LAP_W       = DEF_LAP_W,
  localparam int PW          = $clog2(BOARD_SIZE),
  localparam int IW          = $clog2(MAX_PLAYERS)
) (
  input  logic                         B,
  input  logic                         rst,
  input  logic [N_W-1:0]               n_players,
  input  logic                         init,
  input  logic                         move_valid,
  input  logic [IW-1:0]                move_id,
  input  logic [STEP_W-1:0]            move_step,
  input  logic                         move_back,
  output logic [MAX_PLAYERS*PW-1:0]    pos_flat,
  output logic [MAX_PLAYERS*LAP_W-1:0] lap_flat,
  output logic                         move_done,
  output logic                         move_err,
  output logic                         catch_hit,
  output logic [IW-1:0]                catch_id
);

  localparam logic [LAP_W-1:0] LAP_MAX = '1;

  // Invalid player counts select no ROM entry, leaving every slot at tile 0.
  function automatic logic [PW-1:0] start_rom(input int i, input logic [N_W-1:0] n);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 2; k <= MAX_PLAYERS; k++) begin
      if (n == N_W'(k)) r = PW'(start_offset(i, k, BOARD_SIZE));
    end
    return r;
  endfunction

  logic [PW-1:0]          pos [MAX_PLAYERS];
  logic [LAP_W-1:0]       lap [MAX_PLAYERS];
  logic [N_W-1:0]         n_reg;
  logic                   n_ok;
  logic                   accept;
  logic [PW-1:0]          cur_pos;
  logic [PW-1:0]          next_pos;
  logic                   wrap;
  logic                   borrow;
  logic [MAX_PLAYERS-1:0] match;
  logic                   hit;
  logic [IW-1:0]          hit_id;

  assign n_ok    = (n_reg >= N_W'(2)) && (n_reg <= N_W'(MAX_PLAYERS));
  assign accept  = move_valid && n_ok && (N_W'(move_id) < n_reg);
  assign cur_pos = pos[move_id];

  player_pos_tracker_ring_step #(
    .BOARD_SIZE (BOARD_SIZE),
    .STEP_W     (STEP_W),
    .PW         (PW)
  ) u_ring_step (
    .pos      (cur_pos),
    .step     (move_step),
    .back     (move_back),
    .next_pos (next_pos),
    .wrap     (wrap),
    .borrow   (borrow)
  );

  for (genvar g = 0; g < MAX_PLAYERS; g++) begin : g_slot
    assign match[g] = (move_step != '0) && (N_W'(g) < n_reg) &&
                      (IW'(g) != move_id) && (pos[g] == next_pos);
    assign pos_flat[g*PW +: PW]       = pos[g];
    assign lap_flat[g*LAP_W +: LAP_W] = lap[g];
  end

  // Descending scan so the lowest-index landed-on player wins.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int j = MAX_PLAYERS - 1; j >= 0; j--) begin
      hit    = hit | match[j];
      hit_id = match[j] ? IW'(j) : hit_id;
    end
  end

  // Position/lap banks, sampled player count and the registered result pulses.
  always_ff @(posedge B or negedge rst) begin
    if (!rst) begin
      n_reg     <= n_players;
      move_done <= 1'b0;
      move_err  <= 1'b0;
      catch_hit <= 1'b0;
      catch_id  <= '0;
      for (int i = 0; i < MAX_PLAYERS; i++) begin
        pos[i] <= start_rom(i, n_players);
        lap[i] <= '0;
      end
    end else if (init) begin
      n_reg     <= n_players;
      move_done <= 1'b0;
      move_err  <= 1'b0;
      catch_hit <= 1'b0;
      catch_id  <= '0;
      for (int i = 0; i < MAX_PLAYERS; i++) begin
        pos[i] <= start_rom(i, n_players);
        lap[i] <= '0;
      end
    end else begin
      move_done <= accept;
      move_err  <= move_valid && !accept;
      catch_hit <= accept && hit;
      catch_id  <= hit_id;
      if (accept) begin
        pos[move_id] <= next_pos;
        if (wrap && lap[move_id] != LAP_MAX) begin
          lap[move_id] <= lap[move_id] + LAP_W'(1);
        end else if (borrow && lap[move_id] != '0) begin
          lap[move_id] <= lap[move_id] - LAP_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_player_pos_tracker.sv
// Self-checking bench for player_pos_tracker: directed table, hand sequences
// and random moves against a modulo-arithmetic reference model.
module tb_player_pos_tracker;

  localparam int NP = 4;
  localparam int BS = 24;
  localparam int PW = 5;
  localparam int LMAX = 15;

  logic        B = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  n_players = 4'd3;
  logic        init = 1'b0;
  logic        move_valid = 1'b0;
  logic [1:0]  move_id = 2'd0;
  logic [2:0]  move_step = 3'd0;
  logic        move_back = 1'b0;
  logic [19:0] pos_flat;
  logic [15:0] lap_flat;
  logic        move_done, move_err, catch_hit;
  logic [1:0]  catch_id;

  logic [3:0]  b_n = 4'd2;
  logic        b_init = 1'b0;
  logic        b_valid = 1'b0;
  logic [1:0]  b_id = 2'd0;
  logic [2:0]  b_step = 3'd0;
  logic        b_back = 1'b0;
  logic [15:0] b_pos_flat;
  logic [15:0] b_lap_flat;
  logic        b_done, b_err, b_hit;
  logic [1:0]  b_cid;

  player_pos_tracker dut (
    .B(B), .rst(rst), .n_players(n_players), .init(init),
    .move_valid(move_valid), .move_id(move_id), .move_step(move_step),
    .move_back(move_back), .pos_flat(pos_flat), .lap_flat(lap_flat),
    .move_done(move_done), .move_err(move_err), .catch_hit(catch_hit),
    .catch_id(catch_id)
  );

  player_pos_tracker #(.BOARD_SIZE(10)) dut10 (
    .B(B), .rst(rst), .n_players(b_n), .init(b_init),
    .move_valid(b_valid), .move_id(b_id), .move_step(b_step),
    .move_back(b_back), .pos_flat(b_pos_flat), .lap_flat(b_lap_flat),
    .move_done(b_done), .move_err(b_err), .catch_hit(b_hit),
    .catch_id(b_cid)
  );

  always #5 B = ~B;

  int checks = 0;
  int failures = 0;
  int mpos[NP];
  int mlap[NP];
  int mn;

  typedef struct {
    int id; int st; int bk; int epos; int elap; int ehit; int ecid;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int dpos(input int i);
    return int'(pos_flat[i*PW +: PW]);
  endfunction

  function automatic int dlap(input int i);
    return int'(lap_flat[i*4 +: 4]);
  endfunction

  task automatic tick();
    @(posedge B);
    #1;
  endtask

  task automatic m_load(input int n);
    mn = n;
    for (int i = 0; i < NP; i++) begin
      mpos[i] = (n >= 2 && n <= NP && i < n) ? (i * BS) / n : 0;
      mlap[i] = 0;
    end
  endtask

  task automatic m_move(input int id, input int st, input int bk,
                        output int d, output int e, output int h, output int c);
    int raw, np;
    d = 0; e = 0; h = 0; c = 0;
    if (mn < 2 || mn > NP || id >= mn) begin
      e = 1;
    end else begin
      d = 1;
      raw = bk ? mpos[id] - st : mpos[id] + st;
      if (raw < 0 && mlap[id] > 0) mlap[id]--;
      if (raw >= BS && mlap[id] < LMAX) mlap[id]++;
      np = (raw + BS) % BS;
      if (st != 0)
        for (int j = NP - 1; j >= 0; j--)
          if (j < mn && j != id && mpos[j] == np) begin h = 1; c = j; end
      mpos[id] = np;
    end
  endtask

  task automatic check_all(input string tag, input int d, input int e, input int h, input int c);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s_pos%0d", tag, i), dpos(i), mpos[i]);
      chk($sformatf("%s_lap%0d", tag, i), dlap(i), mlap[i]);
    end
    chk({tag, "_done"}, int'(move_done), d);
    chk({tag, "_err"}, int'(move_err), e);
    chk({tag, "_hit"}, int'(catch_hit), h);
    if (h != 0) chk({tag, "_cid"}, int'(catch_id), c);
  endtask

  task automatic model_step(input string tag, input int id, input int st, input int bk);
    int d, e, h, c;
    move_valid = 1'b1;
    move_id    = 2'(id);
    move_step  = 3'(st);
    move_back  = bk[0];
    tick();
    m_move(id, st, bk, d, e, h, c);
    check_all(tag, d, e, h, c);
  endtask

  task automatic do_init(input int n);
    n_players = 4'(n);
    init = 1'b1;
    tick();
    init = 1'b0;
    m_load(n);
  endtask

  initial begin
    int p, l, eh;
    tbl[0] = '{0, 6, 0,  6, 0, 1, 1};
    tbl[1] = '{1, 7, 0, 13, 0, 0, 0};
    tbl[2] = '{3, 7, 0,  1, 1, 0, 0};
    tbl[3] = '{3, 2, 1, 23, 0, 0, 0};
    tbl[4] = '{2, 1, 0, 13, 0, 1, 1};
    tbl[5] = '{2, 0, 0, 13, 0, 0, 0};
    tbl[6] = '{0, 7, 0, 13, 0, 1, 1};
    tbl[7] = '{3, 3, 1, 20, 0, 0, 0};

    // Reset with three players, then a later n_players change must be ignored.
    repeat (2) @(posedge B);
    #1 rst = 1'b1;
    tick();
    m_load(3);
    chk("rst_pos1", dpos(1), 8);
    chk("rst_pos2", dpos(2), 16);
    check_all("reset", 0, 0, 0, 0);
    n_players = 4'd4;
    model_step("ignored_n", 3, 1, 0);
    move_valid = 1'b0;
    tick();
    check_all("idle", 0, 0, 0, 0);

    // Two players: forward twice across the wrap, then back across it.
    do_init(2);
    model_step("n2_fwd_a", 1, 7, 0);
    chk("n2_fwd_a_abs", dpos(1), 19);
    model_step("n2_fwd_b", 1, 7, 0);
    chk("n2_wrap_abs", dpos(1), 2);
    chk("n2_lap_abs", dlap(1), 1);
    model_step("n2_back", 1, 3, 1);
    chk("n2_back_abs", dpos(1), 23);
    model_step("n2_badid", 3, 2, 0);
    move_valid = 1'b0;

    // init and a move in the same cycle: only the reload happens.
    n_players = 4'd4;
    move_valid = 1'b1; move_id = 2'd0; move_step = 3'd5; move_back = 1'b0;
    init = 1'b1;
    tick();
    init = 1'b0;
    move_valid = 1'b0;
    m_load(4);
    check_all("init_beats_move", 0, 0, 0, 0);

    // Directed four-player table.
    for (int k = 0; k < 8; k++) begin
      move_valid = 1'b1;
      move_id    = 2'(tbl[k].id);
      move_step  = 3'(tbl[k].st);
      move_back  = tbl[k].bk[0];
      tick();
      chk($sformatf("tbl%0d_pos", k), dpos(tbl[k].id), tbl[k].epos);
      chk($sformatf("tbl%0d_lap", k), dlap(tbl[k].id), tbl[k].elap);
      chk($sformatf("tbl%0d_done", k), int'(move_done), 1);
      chk($sformatf("tbl%0d_err", k), int'(move_err), 0);
      chk($sformatf("tbl%0d_hit", k), int'(catch_hit), tbl[k].ehit);
      if (tbl[k].ehit != 0) chk($sformatf("tbl%0d_cid", k), int'(catch_id), tbl[k].ecid);
    end
    move_valid = 1'b0;

    // Invalid player count rejects everything.
    do_init(5);
    check_all("bad_n_init", 0, 0, 0, 0);
    model_step("bad_n_move", 0, 3, 0);
    move_valid = 1'b0;

    // Random moves with back-to-back valid and occasional re-init.
    do_init(4);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 24) == 0) begin
        move_valid = 1'b0;
        do_init(int'($urandom_range(1, 5)));
      end
      model_step("rnd", int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1)));
    end
    move_valid = 1'b0;

    // Reset asserted while a done pulse is showing clears it.
    do_init(4);
    move_valid = 1'b1; move_id = 2'd0; move_step = 3'd3; move_back = 1'b0;
    tick();
    move_valid = 1'b0;
    chk("pre_rst_done", int'(move_done), 1);
    rst = 1'b0;
    #1;
    chk("rst_kill_done", int'(move_done), 0);
    chk("rst_reload_pos0", dpos(0), 0);
    #2 rst = 1'b1;
    tick();
    m_load(4);
    check_all("after_kill", 0, 0, 0, 0);

    // Ten-tile board: lap counter saturates, catch on player 1 at tile 5.
    b_init = 1'b1;
    tick();
    b_init = 1'b0;
    p = 0; l = 0;
    for (int k = 0; k < 40; k++) begin
      b_valid = 1'b1; b_id = 2'd0; b_step = 3'd7; b_back = 1'b0;
      tick();
      p = p + 7;
      if (p >= 10) begin
        p = p % 10;
        if (l < LMAX) l++;
      end
      eh = (p == 5) ? 1 : 0;
      chk("b10_done", int'(b_done), 1);
      chk("b10_err", int'(b_err), 0);
      chk("b10_hit", int'(b_hit), eh);
      if (eh != 0) chk("b10_cid", int'(b_cid), 1);
    end
    b_valid = 1'b0;
    tick();
    chk("b10_pos0", int'(b_pos_flat[3:0]), p);
    chk("b10_lap_sat", int'(b_lap_flat[3:0]), LMAX);
    chk("b10_pos1", int'(b_pos_flat[7:4]), 5);
    chk("b10_done_clear", int'(b_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
